// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : reset_sequencer
// Brief   : Releases NUM_STAGES resets in order once PLL lock is stable;
//           re-asserts all of them on lock loss and counts loss events.
//           Optional macro RESET_SEQ_SOFT_REQ_EN adds soft_reset_req_in.
// Rev     : 1.0
// ============================================================================
module reset_sequencer #(
  parameter int NUM_STAGES         = 4,
  parameter int MIN_ASSERT_CYCLES  = 8,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int STAGE_DELAY_CYCLES = 16
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  pll_locked_in,
`ifdef RESET_SEQ_SOFT_REQ_EN
  input  logic                  soft_reset_req_in,
`endif
  output logic [NUM_STAGES-1:0] stage_reset_out,
  output logic                  seq_done_out,
  output logic [7:0]            lock_lost_count_out
);

  localparam int c_max_ab     = (MIN_ASSERT_CYCLES > LOCK_STABLE_CYCLES) ?
                                MIN_ASSERT_CYCLES : LOCK_STABLE_CYCLES;
  localparam int c_max_cycles = (c_max_ab > STAGE_DELAY_CYCLES) ? c_max_ab : STAGE_DELAY_CYCLES;
  localparam int c_cnt_w      = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;
  localparam int c_idx_w      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [c_cnt_w-1:0] c_assert_last = c_cnt_w'(MIN_ASSERT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_lock_last   = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_stage_last  = c_cnt_w'(STAGE_DELAY_CYCLES - 1);
  localparam logic [c_idx_w-1:0] c_last_idx    = c_idx_w'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  (* ASYNC_REG = "TRUE" *) logic lock_meta_q;
  (* ASYNC_REG = "TRUE" *) logic lock_sync_q;

  state_t                  state_q, state_d;
  logic [c_cnt_w-1:0]      cnt_q, cnt_d;
  logic [c_idx_w-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    done_q, done_d;
  logic [7:0]              lost_q, lost_d;
  logic                    w_soft_req;

`ifdef RESET_SEQ_SOFT_REQ_EN
  assign w_soft_req = soft_reset_req_in;
`else
  assign w_soft_req = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked_in;
      lock_sync_q <= lock_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
    lost_d  = lost_q;

    case (state_q)
      ST_ASSERT: begin
        stage_d = '1;
        done_d  = 1'b0;
        if (w_soft_req) begin
          cnt_d = '0;
        end else if (cnt_q == c_assert_last) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (w_soft_req || !lock_sync_q) begin
          cnt_d = '0;
        end else if (cnt_q == c_lock_last) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q == c_stage_last) begin
          cnt_d   = '0;
          stage_d = stage_q & ~(NUM_STAGES'(1) << idx_q);
          if (idx_q == c_last_idx) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + c_idx_w'(1);
          end
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      ST_DONE: begin
        stage_d = '0;
        done_d  = 1'b1;
      end
      default: state_d = ST_ASSERT;
    endcase

    // Lock loss or soft request overrides any release activity on this edge
    if ((state_q == ST_RELEASE || state_q == ST_DONE) && (!lock_sync_q || w_soft_req)) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      stage_d = '1;
      done_d  = 1'b0;
      if (!lock_sync_q && (lost_q != 8'hFF)) begin
        lost_d = lost_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '1;
      done_q  <= 1'b0;
      lost_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      lost_q  <= lost_d;
    end
  end

  assign stage_reset_out     = stage_q;
  assign seq_done_out        = done_q;
  assign lock_lost_count_out = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_reset_sequencer
// Brief   : Random lock-drop stimulus scored against an edge-arithmetic model.
// Rev     : 1.0
// ============================================================================
module tb_reset_sequencer;

  localparam int NS     = 4;
  localparam int MIN_A  = 8;
  localparam int LOCK_S = 256;
  localparam int STG    = 16;

  logic          clk_in        = 1'b0;
  logic          reset_in      = 1'b1;
  logic          pll_locked_in = 1'b1;
`ifdef RESET_SEQ_SOFT_REQ_EN
  logic          soft_reset_req_in = 1'b0;
`endif
  logic [NS-1:0] stage_reset_out;
  logic          seq_done_out;
  logic [7:0]    lock_lost_count_out;

  reset_sequencer #(
    .NUM_STAGES        (NS),
    .MIN_ASSERT_CYCLES (MIN_A),
    .LOCK_STABLE_CYCLES(LOCK_S),
    .STAGE_DELAY_CYCLES(STG)
  ) dut (
    .clk_in             (clk_in),
    .reset_in           (reset_in),
    .pll_locked_in      (pll_locked_in),
`ifdef RESET_SEQ_SOFT_REQ_EN
    .soft_reset_req_in  (soft_reset_req_in),
`endif
    .stage_reset_out    (stage_reset_out),
    .seq_done_out       (seq_done_out),
    .lock_lost_count_out(lock_lost_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          edge_no;
    logic [NS-1:0] stage;
    logic        done;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: sequence timing expressed as edge arithmetic
  int m_edge, m_assert_end, m_run, m_rel_start, m_cnt;
  bit m_lh1, m_lh2;

  task automatic model_reset();
    m_edge = 0; m_assert_end = MIN_A; m_run = 0; m_rel_start = -1; m_cnt = 0;
    m_lh1 = 1'b0; m_lh2 = 1'b0;
  endtask

  task automatic model_step(input bit lk, input bit sr);
    bit   ls;
    int   k;
    exp_t e;
    m_edge++;
    ls = m_lh2; m_lh2 = m_lh1; m_lh1 = lk;
    if (m_edge <= m_assert_end) begin
      if (sr) m_assert_end = m_edge + MIN_A;
    end else if (m_rel_start < 0) begin
      if (sr || !ls) m_run = 0;
      else           m_run++;
      if (m_run == LOCK_S) begin m_rel_start = m_edge; m_run = 0; end
    end else if (!ls || sr) begin
      m_assert_end = m_edge + MIN_A; m_rel_start = -1; m_run = 0;
      if (!ls && m_cnt < 255) m_cnt++;
    end
    k = (m_rel_start < 0) ? 0 : (m_edge - m_rel_start) / STG;
    if (k > NS) k = NS;
    e.edge_no = m_edge;
    for (int i = 0; i < NS; i++) e.stage[i] = (i >= k);
    e.done = (k == NS);
    e.cnt  = 8'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit lk, input bit sr);
    pll_locked_in = lk;
`ifdef RESET_SEQ_SOFT_REQ_EN
    soft_reset_req_in = sr;
`endif
    model_step(lk, sr);
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired at edge %0d", name, m_edge);
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    #1;
    check("rst_stage", stage_reset_out, 'hF);
    check("rst_done", seq_done_out, 0);
    check("rst_count", lock_lost_count_out, 0);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b0;
    model_reset();
  endtask

  // Returns the edge at which seq_done_out was first seen high, or -1
  task automatic run_until_done(input int bound, input bit sr_first, output int at_edge);
    at_edge = -1;
    for (int i = 0; i < bound; i++) begin
      cycle(1'b1, (i == 0) ? sr_first : 1'b0);
      if (seq_done_out) begin at_edge = m_edge; break; end
    end
    if (at_edge < 0) fail_timeout("wait_done");
  endtask

  // Scoreboard monitor: one expected entry per clocked edge out of reset
  always @(posedge clk_in) begin
    exp_t e;
    #1;
    if (!reset_in && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (stage_reset_out !== e.stage || seq_done_out !== e.done || lock_lost_count_out !== e.cnt) begin
        n_errors++;
        $display("FAIL scoreboard edge %0d: got stage=%b done=%b count=%0d expected stage=%b done=%b count=%0d",
                 e.edge_no, stage_reset_out, seq_done_out, lock_lost_count_out, e.stage, e.done, e.cnt);
      end
    end
  end

  initial begin
    int  at, drop_left, base;
    bit  lk, sr;
    @(negedge clk_in);

    // Clean sequence with lock high throughout
    do_reset();
    for (int i = 1; i <= 340; i++) begin
      cycle(1'b1, 1'b0);
      if (i == 279) check("A_stage_e279", stage_reset_out, 'hF);
      if (i == 280) check("A_stage_e280", stage_reset_out, 'hE);
      if (i == 296) check("A_stage_e296", stage_reset_out, 'hC);
      if (i == 312) check("A_stage_e312", stage_reset_out, 'h8);
      if (i == 327) check("A_done_e327", seq_done_out, 0);
      if (i == 328) check("A_stage_e328", stage_reset_out, 'h0);
      if (i == 328) check("A_done_e328", seq_done_out, 1);
      if (i == 340) check("A_count", lock_lost_count_out, 0);
    end

    // Lock low while waiting, then a one-cycle drop after completion
    do_reset();
    for (int i = 1; i <= 483; i++) begin
      cycle(!(i >= 100 && i <= 150) && (i != 481), 1'b0);
      if (i == 423) check("B_stage_e423", stage_reset_out, 'hF);
      if (i == 424) check("B_stage_e424", stage_reset_out, 'hE);
      if (i == 471) check("B_done_e471", seq_done_out, 0);
      if (i == 472) check("B_done_e472", seq_done_out, 1);
      if (i == 480) check("B_count", lock_lost_count_out, 0);
      if (i == 482) check("C_done_e482", seq_done_out, 1);
    end
    check("C_stage_reassert", stage_reset_out, 'hF);
    check("C_done_drop", seq_done_out, 0);
    check("C_count", lock_lost_count_out, 1);
    run_until_done(400, 1'b0, at);
    check("C_redone_edge", at, 811);

`ifdef RESET_SEQ_SOFT_REQ_EN
    // Soft request while done: re-sequence without counting
    base = m_edge + 1;
    cycle(1'b1, 1'b1);
    check("S_stage_reassert", stage_reset_out, 'hF);
    check("S_count_hold", lock_lost_count_out, 1);
    run_until_done(400, 1'b0, at);
    check("S_redone_edge", at, base + 328);
`endif

    // Random lock dropouts (and soft requests when present)
    drop_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (drop_left > 0) begin
        lk = 1'b0; drop_left--;
      end else if ($urandom_range(0, 199) == 0) begin
        lk = 1'b0; drop_left = $urandom_range(0, 3);
      end else begin
        lk = 1'b1;
      end
`ifdef RESET_SEQ_SOFT_REQ_EN
      sr = ($urandom_range(0, 499) == 0);
`else
      sr = 1'b0;
`endif
      cycle(lk, sr);
    end

    // Saturation of the lock-loss counter
    do_reset();
    for (int l = 0; l < 260; l++) begin
      at = 0;
      while (m_rel_start < 0 && at < 600) begin cycle(1'b1, 1'b0); at++; end
      if (m_rel_start < 0) begin fail_timeout("sat_wait_release"); break; end
      repeat ($urandom_range(0, 7)) cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
    end
    check("E_count_sat", lock_lost_count_out, 255);

    // Reset clears the count; then async reset in the middle of release
    do_reset();
    at = -1;
    for (int i = 0; i < 400; i++) begin
      cycle(1'b1, 1'b0);
      if (stage_reset_out == 4'b1100) begin at = m_edge; break; end
    end
    if (at < 0) fail_timeout("F_wait_1100");
    check("F_edge_1100", at, 296);
    do_reset();
    check("F_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
